// File: rtl/arm_flags_pkg.sv
// Shared flag definitions for the status flag unit.
// Flag order in every 4-bit flag vector is {z,c,n,v}.
package arm_flags_pkg;

  typedef logic [3:0] flags_t;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/flag_track_shreg.sv
// In-flight flag-writer tracker: one bit per pipeline stage between decode
// issue and the execute flag write. o_trk[DEPTH-1] is the instruction in
// execute. Also provides the population count of the tracker.
module flag_track_shreg #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_issue,
  input  logic                       i_stall,
  input  logic                       i_flush,
  output logic [DEPTH-1:0]           o_trk,
  output logic [$clog2(DEPTH+1)-1:0] o_cnt
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_trk;
  logic [CW-1:0]    w_cnt;

  // Shift issued flag writers toward execute; flush kills the younger slots,
  // the execute slot is left alone so its write can still complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trk <= '0;
    end else if (i_flush) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        r_trk[i] <= 1'b0;
      end
      r_trk[0] <= 1'b0;
    end else if (!i_stall) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_trk[i] <= r_trk[i-1];
      end
      r_trk[0] <= i_issue;
    end
  end

  // Count of in-flight flag writers.
  always_comb begin
    w_cnt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_cnt = w_cnt + CW'(r_trk[i]);
    end
  end

  assign o_trk = r_trk;
  assign o_cnt = w_cnt;

endmodule

// File: rtl/status_flag_unit.sv
// Status register {z,c,n,v} with execute-stage update, in-flight flag-writer
// tracking and decode hazard generation for conditional instructions.
// Optional feature macro: FLAG_FWD_EN (execute flags bypassed onto sr and the
// execute slot excluded from the hazard).
module status_flag_unit
  import arm_flags_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            id_valid,
  input  logic                            id_s_bit,
  input  logic [3:0]                      id_cond,
  input  logic                            stall,
  input  logic                            flush,
  input  logic                            ex_s_update,
  input  logic [3:0]                      ex_flags,
  output logic [3:0]                      sr,
  output logic                            flag_hazard,
  output logic [$clog2(PIPE_DEPTH+1)-1:0] pending_cnt,
  output logic                            proto_err
);

  flags_t                          r_sr;
  logic                            r_proto_err;
  logic [PIPE_DEPTH-1:0]           w_trk;
  logic [PIPE_DEPTH-1:0]           w_counted;
  logic [$clog2(PIPE_DEPTH+1)-1:0] w_cnt;
  logic                            w_hazard;
  logic                            w_issue;

  assign w_issue = id_valid & id_s_bit & ~w_hazard & ~flush;

  flag_track_shreg #(
    .DEPTH (PIPE_DEPTH)
  ) u_track (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_issue (w_issue),
    .i_stall (stall),
    .i_flush (flush),
    .o_trk   (w_trk),
    .o_cnt   (w_cnt)
  );

  // Select which tracker entries can still block a conditional instruction.
  always_comb begin
    w_counted = w_trk;
`ifdef FLAG_FWD_EN
    w_counted[PIPE_DEPTH-1] = 1'b0;
`endif
  end

  assign w_hazard = id_valid & (id_cond != COND_AL) & (w_counted != '0);

  // Capture execute flags when the pipeline advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '0;
    end else if (ex_s_update && !stall) begin
      r_sr <= ex_flags;
    end
  end

  // Sticky error when the execute write disagrees with the tracked writer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_proto_err <= 1'b0;
    end else if (!stall && (ex_s_update != w_trk[PIPE_DEPTH-1])) begin
      r_proto_err <= 1'b1;
    end
  end

`ifdef FLAG_FWD_EN
  assign sr = ex_s_update ? ex_flags : r_sr;
`else
  assign sr = r_sr;
`endif

  assign flag_hazard = w_hazard;
  assign pending_cnt = w_cnt;
  assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_status_flag_unit.sv
// Bench for status_flag_unit, default build (FLAG_FWD_EN undefined), PIPE_DEPTH=2.
module tb_status_flag_unit;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic       id_s_bit;
  logic [3:0] id_cond;
  logic       stall;
  logic       flush;
  logic       ex_s_update;
  logic [3:0] ex_flags;
  logic [3:0] sr;
  logic       flag_hazard;
  logic [1:0] pending_cnt;
  logic       proto_err;

  int n_vec;
  int n_err;

  status_flag_unit #(
    .PIPE_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_s_bit    (id_s_bit),
    .id_cond     (id_cond),
    .stall       (stall),
    .flush       (flush),
    .ex_s_update (ex_s_update),
    .ex_flags    (ex_flags),
    .sr          (sr),
    .flag_hazard (flag_hazard),
    .pending_cnt (pending_cnt),
    .proto_err   (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic       s;
    logic [3:0] cond;
    logic       stl;
    logic       fl;
    logic       exu;
    logic [3:0] exf;
    logic       hz;    // expected flag_hazard while inputs are applied
    logic [3:0] sr;    // expected after the edge
    logic [1:0] cnt;
    logic       perr;
  } vec_t;

  vec_t vecs[21];
  vec_t sb_q[$];
  logic hz_s;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    id_valid = 0; id_s_bit = 0; id_cond = 4'b1110;
    stall = 0; flush = 0; ex_s_update = 0; ex_flags = 4'b0000;
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    id_valid = v.valid; id_s_bit = v.s; id_cond = v.cond;
    stall = v.stl; flush = v.fl; ex_s_update = v.exu; ex_flags = v.exf;
    sb_q.push_back(v);
    #1 hz_s = flag_hazard;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk($sformatf("v%0d hazard", idx), {3'b0, hz_s}, {3'b0, e.hz});
    chk($sformatf("v%0d sr", idx), sr, e.sr);
    chk($sformatf("v%0d pending_cnt", idx), {2'b0, pending_cnt}, {2'b0, e.cnt});
    chk($sformatf("v%0d proto_err", idx), {3'b0, proto_err}, {3'b0, e.perr});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    //            valid s  cond     stl fl exu exf      hz sr       cnt    perr
    // issue, then conditionals wait for the tracker to drain
    vecs[0]  = '{1, 1, 4'b1110, 0, 0, 0, 4'b0000, 0, 4'b0000, 2'd1, 0};
    vecs[1]  = '{1, 0, 4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0000, 2'd1, 0};
    vecs[2]  = '{1, 0, 4'b0000, 0, 0, 1, 4'b1001, 1, 4'b1001, 2'd0, 0};
    vecs[3]  = '{1, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b1001, 2'd0, 0};
    // S-bit conditional issues when nothing is in flight
    vecs[4]  = '{1, 1, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b1001, 2'd1, 0};
    vecs[5]  = '{1, 0, 4'b1110, 0, 0, 0, 4'b0000, 0, 4'b1001, 2'd1, 0};
    vecs[6]  = '{1, 1, 4'b1110, 0, 0, 1, 4'b0110, 0, 4'b0110, 2'd1, 0};
    vecs[7]  = '{1, 1, 4'b1110, 0, 0, 0, 4'b0000, 0, 4'b0110, 2'd2, 0};
    // S-bit conditional blocked by the hazard, not issued
    vecs[8]  = '{1, 1, 4'b0000, 0, 0, 1, 4'b0011, 1, 4'b0011, 2'd1, 0};
    // stall for 3 cycles with a pending write, then it lands
    vecs[9]  = '{0, 0, 4'b1110, 1, 0, 1, 4'b1111, 0, 4'b0011, 2'd1, 0};
    vecs[10] = '{0, 0, 4'b1110, 1, 0, 1, 4'b1111, 0, 4'b0011, 2'd1, 0};
    vecs[11] = '{0, 0, 4'b1110, 1, 0, 1, 4'b1111, 0, 4'b0011, 2'd1, 0};
    vecs[12] = '{0, 0, 4'b1110, 0, 0, 1, 4'b1111, 0, 4'b1111, 2'd0, 0};
    // fill tracker to 2'b11, then flush: younger slot dropped, write lands
    vecs[13] = '{1, 1, 4'b1110, 0, 0, 0, 4'b0000, 0, 4'b1111, 2'd1, 0};
    vecs[14] = '{1, 1, 4'b1110, 0, 0, 0, 4'b0000, 0, 4'b1111, 2'd2, 0};
    vecs[15] = '{1, 1, 4'b1110, 0, 1, 1, 4'b0101, 0, 4'b0101, 2'd1, 0};
    vecs[16] = '{0, 0, 4'b1110, 0, 0, 1, 4'b0101, 0, 4'b0101, 2'd0, 0};
    // flush during stall clears the young slot, sr holds
    vecs[17] = '{1, 1, 4'b1110, 0, 0, 0, 4'b0000, 0, 4'b0101, 2'd1, 0};
    vecs[18] = '{0, 0, 4'b1110, 1, 1, 1, 4'b1010, 0, 4'b0101, 2'd0, 0};
    // unexpected execute write: sticky proto_err
    vecs[19] = '{0, 0, 4'b1110, 0, 0, 1, 4'b1100, 0, 4'b1100, 2'd0, 1};
    vecs[20] = '{0, 0, 4'b1110, 0, 0, 0, 4'b0000, 0, 4'b1100, 2'd0, 1};

    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset sr", sr, 4'b0000);
    chk("reset pending_cnt", {2'b0, pending_cnt}, 4'd0);
    chk("reset proto_err", {3'b0, proto_err}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      apply(vecs[i], i);
    end

    // Mid-run asynchronous reset with a writer in flight and proto_err set.
    @(negedge clk);
    id_valid = 1; id_s_bit = 1; id_cond = 4'b1110;
    @(posedge clk);
    #1;
    chk("pre-reset pending_cnt", {2'b0, pending_cnt}, 4'd1);
    @(negedge clk);
    drive_idle();
    #2 rst_n = 1'b0;
    #1;
    chk("async reset sr", sr, 4'b0000);
    chk("async reset pending_cnt", {2'b0, pending_cnt}, 4'd0);
    chk("async reset proto_err", {3'b0, proto_err}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    id_valid = 1; id_s_bit = 0; id_cond = 4'b0000;
    #1;
    chk("post-reset hazard", {3'b0, flag_hazard}, 4'd0);
    @(posedge clk);
    #1;
    chk("post-reset proto_err", {3'b0, proto_err}, 4'd0);
    chk("post-reset pending_cnt", {2'b0, pending_cnt}, 4'd0);
    drive_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
